// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction and data requesters: each request
// is parked in a per-port holding register and issued one at a time, round-robin.
module mem_port_arbiter (
    input  logic        rst,
    input  logic        clk,
    input  logic        imem_valid_i,
    input  logic        imem_fence_i,
    input  logic [31:0] imem_addr_i,
    input  logic [31:0] imem_wdata_i,
    input  logic [3:0]  imem_wstrb_i,
    output logic        imem_ready_o,
    output logic [31:0] imem_rdata_o,
    input  logic        dmem_valid_i,
    input  logic        dmem_fence_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_wstrb_i,
    output logic        dmem_ready_o,
    output logic [31:0] dmem_rdata_o,
    output logic        mem_valid_o,
    output logic        mem_instr_o,
    output logic        mem_fence_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);
    // state  | meaning
    // IDLE   | no transaction open; arbitrate and issue in the same cycle
    // BUSY_I | instruction request on the memory port, waiting for ready
    // BUSY_D | data request on the memory port, waiting for ready
    localparam int         REQ_W  = 69;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic       GNT_I  = 1'b0;
    localparam logic       GNT_D  = 1'b1;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             pend_i_vld_q, pend_i_vld_d;
    logic             pend_d_vld_q, pend_d_vld_d;
    logic [REQ_W-1:0] pend_i_q, pend_i_d;
    logic [REQ_W-1:0] pend_d_q, pend_d_d;
    logic [REQ_W-1:0] cur_q, cur_d;

    logic [REQ_W-1:0] fresh_i, fresh_d;
    logic [REQ_W-1:0] req_i, req_d, issue_req;
    logic             idle, busy_i, busy_d;
    logic             cand_i, cand_d, grant_i, grant_d;

    // Request bundle layout: {fence, addr, wdata, wstrb}; mem_instr comes from the grant.
    assign fresh_i = {imem_fence_i, imem_addr_i, imem_wdata_i, imem_wstrb_i};
    assign fresh_d = {dmem_fence_i, dmem_addr_i, dmem_wdata_i, dmem_wstrb_i};
    assign req_i   = pend_i_vld_q ? pend_i_q : fresh_i;
    assign req_d   = pend_d_vld_q ? pend_d_q : fresh_d;

    assign idle    = (state_q == IDLE);
    assign busy_i  = (state_q == BUSY_I);
    assign busy_d  = (state_q == BUSY_D);
    assign cand_i  = idle & (pend_i_vld_q | imem_valid_i);
    assign cand_d  = idle & (pend_d_vld_q | dmem_valid_i);
    // On a tie the side that did not win last time goes first.
    assign grant_d = cand_d & (~cand_i | (last_grant_q == GNT_I));
    assign grant_i = cand_i & ~grant_d;
    assign issue_req = grant_d ? req_d : req_i;

    always_comb begin
        mem_valid_o = 1'b0;
        mem_instr_o = 1'b0;
        {mem_fence_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} = '0;
        if (grant_i | grant_d) begin
            mem_valid_o = 1'b1;
            mem_instr_o = grant_i;
            {mem_fence_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} = issue_req;
        end else if (busy_i | busy_d) begin
            mem_valid_o = 1'b1;
            mem_instr_o = busy_i;
            {mem_fence_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} = cur_q;
        end
    end

    assign imem_ready_o = busy_i & mem_ready_i;
    assign dmem_ready_o = busy_d & mem_ready_i;
    assign imem_rdata_o = imem_ready_o ? mem_rdata_i : 32'd0;
    assign dmem_rdata_o = dmem_ready_o ? mem_rdata_i : 32'd0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        pend_i_vld_d = pend_i_vld_q;
        pend_i_d     = pend_i_q;
        pend_d_vld_d = pend_d_vld_q;
        pend_d_d     = pend_d_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = BUSY_I;
                    last_grant_d = GNT_I;
                    cur_d        = issue_req;
                end else if (grant_d) begin
                    state_d      = BUSY_D;
                    last_grant_d = GNT_D;
                    cur_d        = issue_req;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A port that is pending, owns the bus, or is being granted ignores valid.
        if (grant_i) begin
            pend_i_vld_d = 1'b0;
        end else if (imem_valid_i & ~pend_i_vld_q & ~busy_i) begin
            pend_i_vld_d = 1'b1;
            pend_i_d     = fresh_i;
        end

        if (grant_d) begin
            pend_d_vld_d = 1'b0;
        end else if (dmem_valid_i & ~pend_d_vld_q & ~busy_d) begin
            pend_d_vld_d = 1'b1;
            pend_d_d     = fresh_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            pend_i_vld_q <= 1'b0;
            pend_d_vld_q <= 1'b0;
            pend_i_q     <= '0;
            pend_d_q     <= '0;
            cur_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pend_i_vld_q <= pend_i_vld_d;
            pend_d_vld_q <= pend_d_vld_d;
            pend_i_q     <= pend_i_d;
            pend_d_q     <= pend_d_d;
            cur_q        <= cur_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester and memory models drive the DUT,
// expected issues are queued with the stimulus and popped as the DUT issues them.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_valid_i, imem_fence_i;
    logic [31:0] imem_addr_i, imem_wdata_i;
    logic [3:0]  imem_wstrb_i;
    logic        imem_ready_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_valid_i, dmem_fence_i;
    logic [31:0] dmem_addr_i, dmem_wdata_i;
    logic [3:0]  dmem_wstrb_i;
    logic        dmem_ready_o;
    logic [31:0] dmem_rdata_o;
    logic        mem_valid_o, mem_instr_o, mem_fence_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .rst(rst), .clk(clk),
        .imem_valid_i(imem_valid_i), .imem_fence_i(imem_fence_i), .imem_addr_i(imem_addr_i),
        .imem_wdata_i(imem_wdata_i), .imem_wstrb_i(imem_wstrb_i),
        .imem_ready_o(imem_ready_o), .imem_rdata_o(imem_rdata_o),
        .dmem_valid_i(dmem_valid_i), .dmem_fence_i(dmem_fence_i), .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_wstrb_i(dmem_wstrb_i),
        .dmem_ready_o(dmem_ready_o), .dmem_rdata_o(dmem_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_instr_o(mem_instr_o), .mem_fence_o(mem_fence_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct { logic [31:0] addr; logic fence; } req_t;
    typedef struct { logic [31:0] addr; logic instr; logic fence; logic imm; } iss_t;

    req_t iq[$];
    req_t dq[$];
    iss_t exp_q[$];
    iss_t cur;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_ready_cyc = -10;
    logic mem_active = 1'b0;
    int   mem_cnt = 0;
    int   mem_lat = 1;
    int   i_delay = 0;
    int   d_delay = 0;
    int   i_shown = 0;
    logic i_shift = 1'b0;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : ({~a[15:0], a[15:0]} ^ 32'h5A5A_0000);
    endfunction
    function automatic logic [31:0] wdata_for(input logic [31:0] a);
        return a ^ 32'hC3C3_3C3C;
    endfunction
    function automatic logic [3:0] wstrb_for(input logic [31:0] a);
        return a[5:2] | 4'b0001;
    endfunction

    task automatic zero_inputs();
        imem_valid_i = 0; imem_fence_i = 0; imem_addr_i = 0; imem_wdata_i = 0; imem_wstrb_i = 0;
        dmem_valid_i = 0; dmem_fence_i = 0; dmem_addr_i = 0; dmem_wdata_i = 0; dmem_wstrb_i = 0;
        mem_ready_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        zero_inputs();
        iq.delete(); dq.delete(); exp_q.delete();
        mem_active = 0; i_delay = 0; d_delay = 0; i_shown = 0; i_shift = 0;
        last_ready_cyc = -10;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock of the requester/memory models plus the scoreboard comparisons.
    task automatic cycle();
        logic [31:0] a;
        iss_t e;
        @(negedge clk);
        mem_ready_i = 0; mem_rdata_i = 0;
        if (mem_active) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                mem_ready_i = 1;
                mem_rdata_i = data_for(cur.addr);
            end
        end
        if (iq.size() > 0 && i_delay == 0) begin
            a = iq[0].addr;
            if (i_shift && i_shown >= 2) a = a + 32'd4;
            imem_valid_i = 1; imem_addr_i = a; imem_wdata_i = wdata_for(a);
            imem_wstrb_i = wstrb_for(a); imem_fence_i = iq[0].fence;
            i_shown++;
        end else begin
            imem_valid_i = 0; imem_addr_i = 0; imem_wdata_i = 0; imem_wstrb_i = 0; imem_fence_i = 0;
        end
        if (i_delay > 0) i_delay--;
        if (dq.size() > 0 && d_delay == 0) begin
            a = dq[0].addr;
            dmem_valid_i = 1; dmem_addr_i = a; dmem_wdata_i = wdata_for(a);
            dmem_wstrb_i = wstrb_for(a); dmem_fence_i = dq[0].fence;
        end else begin
            dmem_valid_i = 0; dmem_addr_i = 0; dmem_wdata_i = 0; dmem_wstrb_i = 0; dmem_fence_i = 0;
        end
        if (d_delay > 0) d_delay--;
        #1;
        if (mem_active && mem_ready_i) begin
            checks++;
            if ({imem_ready_o, dmem_ready_o} !== {cur.instr, ~cur.instr}) begin
                failures++;
                $display("FAIL resp_ready cyc=%0d got i=%b d=%b want i=%b d=%b", cyc,
                         imem_ready_o, dmem_ready_o, cur.instr, ~cur.instr);
            end
            checks++;
            if ({imem_rdata_o, dmem_rdata_o} !==
                (cur.instr ? {data_for(cur.addr), 32'd0} : {32'd0, data_for(cur.addr)})) begin
                failures++;
                $display("FAIL resp_rdata cyc=%0d got i=%h d=%h want owner=%h other=0", cyc,
                         imem_rdata_o, dmem_rdata_o, data_for(cur.addr));
            end
            if (cur.instr) begin
                if (iq.size() > 0) void'(iq.pop_front());
                i_shown = 0;
            end else if (dq.size() > 0) begin
                void'(dq.pop_front());
            end
            mem_active = 0;
            last_ready_cyc = cyc;
        end else begin
            checks++;
            if (imem_ready_o !== 1'b0 || dmem_ready_o !== 1'b0 ||
                imem_rdata_o !== 32'd0 || dmem_rdata_o !== 32'd0) begin
                failures++;
                $display("FAIL no_resp cyc=%0d got i=%b/%h d=%b/%h want all zero", cyc,
                         imem_ready_o, imem_rdata_o, dmem_ready_o, dmem_rdata_o);
            end
            if (mem_active) begin
                checks++;
                if ({mem_valid_o, mem_instr_o, mem_fence_o, mem_addr_o} !==
                    {1'b1, cur.instr, cur.fence, cur.addr}) begin
                    failures++;
                    $display("FAIL hold cyc=%0d got v=%b i=%b addr=%h want v=1 i=%b addr=%h", cyc,
                             mem_valid_o, mem_instr_o, mem_addr_o, cur.instr, cur.addr);
                end
            end else if (mem_valid_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL issue cyc=%0d got unexpected addr=%h want no issue", cyc, mem_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr_o, mem_instr_o, mem_fence_o, mem_wdata_o, mem_wstrb_o} !==
                        {e.addr, e.instr, e.fence, wdata_for(e.addr), wstrb_for(e.addr)}) begin
                        failures++;
                        $display("FAIL issue cyc=%0d got addr=%h i=%b f=%b wd=%h ws=%h want addr=%h i=%b f=%b",
                                 cyc, mem_addr_o, mem_instr_o, mem_fence_o, mem_wdata_o, mem_wstrb_o,
                                 e.addr, e.instr, e.fence);
                    end
                    if (e.imm) begin
                        checks++;
                        if (cyc != last_ready_cyc + 1) begin
                            failures++;
                            $display("FAIL issue_gap cyc=%0d got issue at %0d want %0d", cyc, cyc,
                                     last_ready_cyc + 1);
                        end
                    end
                    cur = e;
                    mem_active = 1;
                    mem_cnt = mem_lat;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || exp_q.size() > 0 || mem_active) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL timeout got %0d cycles want < %0d (exp left %0d)", n, budget, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_valid_o, mem_instr_o, mem_fence_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== 71'd0) begin
            failures++;
            $display("FAIL reset_mem_in got v=%b addr=%h want all zero", mem_valid_o, mem_addr_o);
        end
        checks++;
        if ({imem_ready_o, imem_rdata_o, dmem_ready_o, dmem_rdata_o} !== 66'd0) begin
            failures++;
            $display("FAIL reset_resp got i=%b d=%b want 0", imem_ready_o, dmem_ready_o);
        end
    endtask

    task automatic test_single_load();
        do_reset();
        mem_lat = 2;
        dq.push_back('{32'h100, 1'b0});
        exp_q.push_back('{32'h100, 1'b0, 1'b0, 1'b0});
        run_until_done(20);
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_lat = 2;
        iq.push_back('{32'h80, 1'b0});
        dq.push_back('{32'h200, 1'b0});
        exp_q.push_back('{32'h200, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{32'h80, 1'b1, 1'b0, 1'b1});
        run_until_done(30);
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < 3; k++) begin
            iq.push_back('{32'h1000 + 32'(k * 4), 1'b0});
            dq.push_back('{32'h2000 + 32'(k * 8), 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{32'h2000 + 32'(k * 8), 1'b0, 1'b0, (k != 0)});
            exp_q.push_back('{32'h1000 + 32'(k * 4), 1'b1, 1'b0, 1'b1});
        end
        run_until_done(60);
    endtask

    task automatic test_hold_changing_addr();
        do_reset();
        mem_lat = 4;
        i_delay = 1;
        i_shift = 1;
        dq.push_back('{32'h300, 1'b0});
        iq.push_back('{32'h80, 1'b0});
        iq.push_back('{32'h84, 1'b0});
        exp_q.push_back('{32'h300, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{32'h80, 1'b1, 1'b0, 1'b1});
        exp_q.push_back('{32'h84, 1'b1, 1'b0, 1'b1});
        run_until_done(60);
    endtask

    task automatic test_fence();
        do_reset();
        mem_lat = 3;
        iq.push_back('{32'h600, 1'b1});
        dq.push_back('{32'h500, 1'b1});
        exp_q.push_back('{32'h500, 1'b0, 1'b1, 1'b0});
        exp_q.push_back('{32'h600, 1'b1, 1'b1, 1'b1});
        run_until_done(30);
    endtask

    task automatic test_spurious_ready();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ready_i = 1;
            mem_rdata_i = $urandom | 32'h1;
            #1;
            checks++;
            if ({imem_ready_o, imem_rdata_o, dmem_ready_o, dmem_rdata_o, mem_valid_o} !== 67'd0) begin
                failures++;
                $display("FAIL spurious_ready got i=%b/%h d=%b/%h v=%b want all zero",
                         imem_ready_o, imem_rdata_o, dmem_ready_o, dmem_rdata_o, mem_valid_o);
            end
        end
        mem_lat = 2;
        dq.push_back('{32'h700, 1'b0});
        exp_q.push_back('{32'h700, 1'b0, 1'b0, 1'b0});
        run_until_done(20);
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat = 5;
        dq.push_back('{32'h400, 1'b0});
        exp_q.push_back('{32'h400, 1'b0, 1'b0, 1'b0});
        cycle();
        cycle();
        @(negedge clk);
        rst = 1'b0;
        zero_inputs();
        dq.delete(); exp_q.delete(); mem_active = 0;
        @(negedge clk);
        rst = 1'b1;
        mem_ready_i = 1;
        mem_rdata_i = 32'h1234_5678;
        #1;
        checks++;
        if ({imem_ready_o, imem_rdata_o, dmem_ready_o, dmem_rdata_o} !== 66'd0) begin
            failures++;
            $display("FAIL reset_mid_resp got i=%b/%h d=%b/%h want all zero",
                     imem_ready_o, imem_rdata_o, dmem_ready_o, dmem_rdata_o);
        end
        checks++;
        if (mem_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_valid got %b want 0", mem_valid_o);
        end
        @(negedge clk);
        mem_ready_i = 0;
        mem_rdata_i = 0;
        #1;
        checks++;
        if (mem_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got %b want 0", mem_valid_o);
        end
        mem_lat = 1;
        dq.push_back('{32'h440, 1'b0});
        exp_q.push_back('{32'h440, 1'b0, 1'b0, 1'b0});
        run_until_done(20);
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_single_load();
        test_simultaneous();
        test_back_to_back();
        test_hold_changing_addr();
        test_fence();
        test_spurious_ready();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
